// File: rtl/keypad_entry.sv
// Keypad entry conditioner: debounces raw decoder codes and builds a signed
// multi-digit value, emitting one-cycle data_valid / input_done / overflow pulses.
module keypad_entry #(
  parameter int         ELEM_WIDTH      = 12,
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter logic [3:0] IDLE_CODE       = 4'hF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            key_code,
  output logic [ELEM_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  input_done,
  output logic [ELEM_WIDTH-2:0] entry_mag,
  output logic                  entry_neg,
  output logic [2:0]            digit_count,
  output logic                  overflow,
  output logic                  busy
);

  // state       | meaning
  // S_IDLE      | no key seen, waiting for a non-idle code
  // S_PRESS_CHK | candidate code must stay stable to be accepted
  // S_HELD      | press accepted, waiting for release (no auto-repeat)
  // S_REL_CHK   | idle code must stay stable to finish the release
  typedef enum logic [1:0] {S_IDLE, S_PRESS_CHK, S_HELD, S_REL_CHK} state_t;

  localparam int MW = ELEM_WIDTH - 1;
  localparam int SW = ELEM_WIDTH + 3;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SW-1:0] MAG_MAX = SW'((1 << (ELEM_WIDTH - 1)) - 1);

  state_t                state_q;
  logic [3:0]            cand_q;
  logic [CW-1:0]         cnt_q;
  logic [MW-1:0]         mag_q;
  logic                  neg_q;
  logic [2:0]            count_q;
  logic [ELEM_WIDTH-1:0] data_out_q;
  logic                  dv_q, done_q, ovf_q;

  logic [CW-1:0]         cnt_d;
  logic                  stable_d;
  logic [SW-1:0]         digit_sum_d;
  logic                  digit_ok_d;
  logic [MW-1:0]         mag_bs_d;
  logic [ELEM_WIDTH-1:0] commit_d;

  assign cnt_d       = cnt_q + CW'(1);
  assign stable_d    = (cnt_d == CW'(DEBOUNCE_CYCLES));
  // mag*10 + d, widened so the range test cannot wrap
  assign digit_sum_d = (SW'(mag_q) << 3) + (SW'(mag_q) << 1) + SW'(cand_q);
  assign digit_ok_d  = (count_q != 3'd4) && (digit_sum_d <= MAG_MAX);
  assign mag_bs_d    = mag_q / MW'(10);
  assign commit_d    = neg_q ? (ELEM_WIDTH'(0) - {1'b0, mag_q}) : {1'b0, mag_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cand_q     <= '0;
      cnt_q      <= '0;
      mag_q      <= '0;
      neg_q      <= 1'b0;
      count_q    <= '0;
      data_out_q <= '0;
      dv_q       <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      dv_q   <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (key_code != IDLE_CODE) begin
            cand_q  <= key_code;
            cnt_q   <= CW'(1);
            state_q <= S_PRESS_CHK;
          end
        end
        S_PRESS_CHK: begin
          if (key_code == cand_q) begin
            cnt_q <= cnt_d;
            if (stable_d) begin
              state_q <= S_HELD;
              case (cand_q)
                4'hA: begin
                  mag_q   <= '0;
                  neg_q   <= 1'b0;
                  count_q <= '0;
                end
                4'hB: neg_q <= ~neg_q;
                4'hC: begin
                  mag_q <= mag_bs_d;
                  if (count_q != 3'd0) count_q <= count_q - 3'd1;
                  if (count_q <= 3'd1) neg_q <= 1'b0;
                end
                4'hD: done_q <= 1'b1;
                4'hE: begin
                  data_out_q <= commit_d;
                  dv_q       <= 1'b1;
                  mag_q      <= '0;
                  neg_q      <= 1'b0;
                  count_q    <= '0;
                end
                default: begin
                  if (cand_q <= 4'd9) begin
                    if (digit_ok_d) begin
                      mag_q   <= digit_sum_d[MW-1:0];
                      count_q <= count_q + 3'd1;
                    end else begin
                      ovf_q <= 1'b1;
                    end
                  end
                end
              endcase
            end
          end else if (key_code == IDLE_CODE) begin
            state_q <= S_IDLE;
          end else begin
            cand_q <= key_code;
            cnt_q  <= CW'(1);
          end
        end
        S_HELD: begin
          if (key_code == IDLE_CODE) begin
            cnt_q   <= CW'(1);
            state_q <= S_REL_CHK;
          end
        end
        S_REL_CHK: begin
          if (key_code == IDLE_CODE) begin
            cnt_q <= cnt_d;
            if (stable_d) state_q <= S_IDLE;
          end else begin
            state_q <= S_HELD;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = dv_q;
  assign input_done  = done_q;
  assign overflow    = ovf_q;
  assign entry_mag   = mag_q;
  assign entry_neg   = neg_q;
  assign digit_count = count_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: directed press scenarios plus random key sequences,
// checked against a press-level arithmetic model of the entry.
module tb_keypad_entry;
  localparam int         W    = 12;
  localparam int         DEB  = 16;
  localparam logic [3:0] IDLE = 4'hF;
  localparam int         MAXV = (1 << (W - 1)) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [3:0]     key_code = IDLE;
  logic [W-1:0]   data_out;
  logic           data_valid, input_done, overflow, entry_neg, busy;
  logic [W-2:0]   entry_mag;
  logic [2:0]     digit_count;

  always #5 clk = ~clk;

  keypad_entry #(.ELEM_WIDTH(W), .DEBOUNCE_CYCLES(DEB), .IDLE_CODE(IDLE)) dut (
    .clk(clk), .rst(rst), .key_code(key_code),
    .data_out(data_out), .data_valid(data_valid), .input_done(input_done),
    .entry_mag(entry_mag), .entry_neg(entry_neg), .digit_count(digit_count),
    .overflow(overflow), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Reference model: the entry as plain integers, updated once per accepted press
  int m_mag = 0, m_cnt = 0, m_out = 0;
  bit m_neg = 1'b0;
  bit x_dv, x_done, x_ovf;
  int e_dv = 0, e_done = 0, e_ovf = 0;

  task automatic model_reset();
    m_mag = 0; m_cnt = 0; m_out = 0; m_neg = 1'b0;
  endtask

  task automatic model_apply(input logic [3:0] c);
    int nv;
    x_dv = 1'b0; x_done = 1'b0; x_ovf = 1'b0;
    if (c <= 4'd9) begin
      nv = m_mag * 10 + int'(c);
      if (m_cnt == 4 || nv > MAXV) begin
        x_ovf = 1'b1; e_ovf++;
      end else begin
        m_mag = nv; m_cnt++;
      end
    end else begin
      case (c)
        4'hA: begin m_mag = 0; m_neg = 1'b0; m_cnt = 0; end
        4'hB: m_neg = !m_neg;
        4'hC: begin
          m_mag = m_mag / 10;
          if (m_cnt > 0) m_cnt--;
          if (m_cnt == 0) m_neg = 1'b0;
        end
        4'hD: begin x_done = 1'b1; e_done++; end
        4'hE: begin
          m_out = m_neg ? -m_mag : m_mag;
          x_dv = 1'b1; e_dv++;
          m_mag = 0; m_neg = 1'b0; m_cnt = 0;
        end
        default: ;
      endcase
    end
  endtask

  int n_dv = 0, n_done = 0, n_ovf = 0, n_multi = 0;
  always @(negedge clk) begin
    if (data_valid === 1'b1) n_dv++;
    if (input_done === 1'b1) n_done++;
    if (overflow === 1'b1) n_ovf++;
    if (int'(data_valid === 1'b1) + int'(input_done === 1'b1) + int'(overflow === 1'b1) > 1)
      n_multi++;
  end

  task automatic check_entry(input string tag);
    chk({tag, " mag"}, entry_mag, m_mag);
    chk({tag, " neg"}, entry_neg, m_neg);
    chk({tag, " count"}, digit_count, m_cnt);
  endtask

  // Starts and ends #1 after a rising edge. hold >= DEB edges, gap > DEB edges.
  task automatic press(input logic [3:0] code, input int hold, input int gap, input int glitch);
    logic [3:0] other;
    if (glitch > 0) begin
      other = 4'((int'(code) + $urandom_range(1, 14)) % 15);
      key_code = other;
      repeat (glitch) @(posedge clk);
      #1;
    end
    key_code = code;
    repeat (DEB - 1) @(posedge clk);
    @(negedge clk);
    chk("early pulse", {data_valid, input_done, overflow}, 3'b000);
    @(posedge clk);
    @(negedge clk);
    model_apply(code);
    chk("pulses", {data_valid, input_done, overflow}, {x_dv, x_done, x_ovf});
    if (x_dv) chk("data_out", data_out, m_out & ((1 << W) - 1));
    check_entry("accept");
    chk("busy held", busy, 1'b1);
    repeat (hold - DEB) @(posedge clk);
    #1;
    key_code = IDLE;
    repeat (gap) @(posedge clk);
    #1;
    chk("busy released", busy, 1'b0);
    chk("data_out hold", data_out, m_out & ((1 << W) - 1));
  endtask

  task automatic drive(input logic [3:0] c, input int n);
    key_code = c;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " data_out"}, data_out, 0);
    chk({tag, " pulses"}, {data_valid, input_done, overflow}, 3'b000);
    chk({tag, " busy"}, busy, 1'b0);
    check_entry(tag);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset");

    // 1,2,3 ENTER
    press(4'h1, 20, 20, 0);
    press(4'h2, 20, 20, 0);
    press(4'h3, 20, 20, 0);
    press(4'hE, 20, 20, 0);
    chk("enter 123", data_out, 123);

    // 4,5 NEGATE ENTER -> -45
    press(4'h4, 20, 20, 0);
    press(4'h5, 20, 20, 0);
    press(4'hB, 20, 20, 0);
    press(4'hE, 20, 20, 0);
    chk("enter -45", data_out, 12'hFD3);

    // bouncing '7' then a long hold
    drive(4'h7, 3); drive(IDLE, 3); drive(4'h7, 3); drive(IDLE, 3);
    press(4'h7, DEB, 20, 0);
    press(4'h7, 40, 20, 0);
    chk("bounce mag", entry_mag, 77);
    press(4'hA, 20, 20, 0);

    // overflow boundary
    press(4'h2, 20, 20, 0);
    press(4'h0, 20, 20, 0);
    press(4'h4, 20, 20, 0);
    press(4'h8, 20, 20, 0);
    chk("ovf mag", entry_mag, 204);
    press(4'h7, 20, 20, 0);
    chk("max mag", entry_mag, 2047);
    press(4'h1, 20, 20, 0);
    press(4'hE, 20, 20, 0);

    // 9,9 BACKSPACE DONE
    press(4'h9, 20, 20, 0);
    press(4'h9, 20, 20, 0);
    press(4'hC, 20, 20, 0);
    press(4'hD, 20, 20, 0);
    chk("done mag", entry_mag, 9);
    press(4'hA, 20, 20, 0);

    // reset in the middle of an ENTER press
    press(4'h5, 20, 20, 0);
    press(4'h6, 20, 20, 0);
    key_code = 4'hE;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1; key_code = IDLE;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_reset_state("rst mid");

    // reset on the very edge that would accept ENTER
    press(4'h3, 20, 20, 0);
    key_code = 4'hE;
    repeat (DEB - 1) @(posedge clk);
    #1;
    rst = 1'b1; key_code = IDLE;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_reset_state("rst accept");
    repeat (DEB + 4) @(posedge clk);
    #1;
    chk("no dv after rst", n_dv, e_dv);

    // random key sequences
    for (int i = 0; i < 80; i++) begin
      int r;
      logic [3:0] c;
      r = $urandom_range(0, 99);
      if (r < 55)      c = 4'($urandom_range(0, 9));
      else if (r < 63) c = 4'hA;
      else if (r < 73) c = 4'hB;
      else if (r < 83) c = 4'hC;
      else if (r < 90) c = 4'hD;
      else             c = 4'hE;
      press(c, $urandom_range(DEB, DEB + 25), $urandom_range(DEB + 1, DEB + 10),
            ($urandom_range(0, 9) < 3) ? $urandom_range(1, DEB - 2) : 0);
    end

    chk("total data_valid", n_dv, e_dv);
    chk("total input_done", n_done, e_done);
    chk("total overflow", n_ovf, e_ovf);
    chk("simultaneous pulses", n_multi, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
